// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: checks alignment and range, drives a ready-handshaked
// memory port, and extends load data back to the pipeline.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16,
    parameter logic [31:0] DM_TOP  = 32'h0000_2FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;

    localparam int unsigned    CNT_W        = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           next_state;
    logic [2:0]       op_reg;
    logic [31:0]      addr_reg;
    logic [31:0]      wdata_reg;
    logic [31:0]      rdata_reg;
    logic [4:0]       code_reg;
    logic [CNT_W-1:0] cnt;

    function automatic logic is_store(input logic [2:0] t);
        return (t >= OP_SW);
    endfunction

    // 2 = word, 1 = half, 0 = byte
    function automatic logic [1:0] acc_size(input logic [2:0] t);
        case (t)
            OP_LW, OP_SW:         return 2'd2;
            OP_LH, OP_LHU, OP_SH: return 2'd1;
            default:              return 2'd0;
        endcase
    endfunction

    function automatic logic access_ok(input logic [2:0] t, input logic [31:0] a);
        logic [1:0] sz;
        logic       aligned;
        logic       in_dm;
        logic       in_timer;
        logic       ok;
        sz       = acc_size(t);
        aligned  = (sz == 2'd2) ? (a[1:0] == 2'b00) :
                   (sz == 2'd1) ? (a[0] == 1'b0) : 1'b1;
        in_dm    = (a <= DM_TOP);
        in_timer = ((a >= 32'h0000_7F00) && (a <= 32'h0000_7F0B)) ||
                   ((a >= 32'h0000_7F10) && (a <= 32'h0000_7F1B));
        ok       = aligned && (in_dm || (in_timer && (sz == 2'd2)));
        // timer count registers are read-only
        if (is_store(t) && ((a == 32'h0000_7F08) || (a == 32'h0000_7F18))) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] t, input logic [1:0] off);
        case (acc_size(t))
            2'd2:    return 4'b1111;
            2'd1:    return 4'b0011 << off;
            default: return 4'b0001 << off;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] t, input logic [31:0] d);
        case (acc_size(t))
            2'd2:    return d;
            2'd1:    return {2{d[15:0]}};
            default: return {4{d[7:0]}};
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] t, input logic [1:0] off,
                                                input logic [31:0] w);
        logic [31:0] s;
        s = w >> {off, 3'b000};
        case (t)
            OP_LW:   return w;
            OP_LH:   return {{16{s[15]}}, s[15:0]};
            OP_LHU:  return {16'h0000, s[15:0]};
            OP_LB:   return {{24{s[7]}}, s[7:0]};
            OP_LBU:  return {24'h00_0000, s[7:0]};
            default: return 32'h0000_0000;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operation capture, wait counter and load capture
    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg    <= 3'd0;
            addr_reg  <= 32'h0000_0000;
            wdata_reg <= 32'h0000_0000;
            rdata_reg <= 32'h0000_0000;
            code_reg  <= 5'd0;
            cnt       <= {CNT_W{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        op_reg    <= op_type;
                        addr_reg  <= addr;
                        wdata_reg <= wdata;
                        cnt       <= {CNT_W{1'b0}};
                        code_reg  <= access_ok(op_type, addr) ? 5'd0 :
                                     (is_store(op_type) ? 5'd5 : 5'd4);
                    end
                end
                REQ: begin
                    if (m_ready) begin
                        rdata_reg <= load_extend(op_reg, addr_reg[1:0], m_rdata);
                    end else if (cnt == TIMEOUT_LAST) begin
                        code_reg <= 5'd7;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and output decode
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        done       = 1'b0;
        rdata      = 32'h0000_0000;
        exc_valid  = 1'b0;
        exc_code   = 5'd0;
        m_req      = 1'b0;
        m_we       = 1'b0;
        m_addr     = 32'h0000_0000;
        m_be       = 4'b0000;
        m_wdata    = 32'h0000_0000;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    stall      = 1'b1;
                    next_state = access_ok(op_type, addr) ? REQ : ERR;
                end else begin
                    next_state = IDLE;
                end
            end
            REQ: begin
                stall   = 1'b1;
                m_req   = 1'b1;
                m_we    = is_store(op_reg);
                m_addr  = {addr_reg[31:2], 2'b00};
                m_be    = byte_en(op_reg, addr_reg[1:0]);
                m_wdata = is_store(op_reg) ? lane_data(op_reg, wdata_reg) : 32'h0000_0000;
                if (m_ready) begin
                    next_state = DONE;
                end else if (cnt == TIMEOUT_LAST) begin
                    next_state = ERR;
                end else begin
                    next_state = REQ;
                end
            end
            DONE: begin
                done       = 1'b1;
                rdata      = rdata_reg;
                next_state = IDLE;
            end
            ERR: begin
                done       = 1'b1;
                exc_valid  = 1'b1;
                exc_code   = code_reg;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store initiator for the P7 CPU. It drives the data-memory/bridge request interface from the pipeline side.
- Checks alignment and address range and raises AdEL/AdES/DBE exception codes.
- Generates byte enables and lane-shifted store data; sign/zero-extends load data.
- Stalls the pipeline while a request is outstanding on a ready-handshaked memory port.

Parameters:
TIMEOUT, 16, max cycles m_req may stay high without m_ready before a DBE exception is raised
DM_TOP, 32'h0000_2FFF, last valid data-memory byte address (DM region starts at 0)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
op_valid  input  1  pipeline presents a memory op; held stable until done
op_type  input  3  0=lw 1=lh 2=lhu 3=lb 4=lbu 5=sw 6=sh 7=sb
addr  input  32  byte address
wdata  input  32  store data (low-aligned)
stall  output  1  freeze pipeline
done  output  1  one-cycle completion pulse
rdata  output  32  extended load result, valid while done=1
exc_valid  output  1  exception flag, valid while done=1
exc_code  output  5  4=AdEL 5=AdES 7=DBE, else 0
m_req  output  1  memory request
m_we  output  1  write request
m_addr  output  32  word-aligned address {addr[31:2],2'b00}
m_be  output  4  byte enables
m_wdata  output  32  lane-shifted store data
m_ready  input  1  memory accepts/completes request this cycle
m_rdata  input  32  read word, valid with m_ready

Behaviour:
- States: IDLE, REQ, DONE, ERR. Reset forces IDLE, clears the timeout counter, and drives every output to 0 the following cycle, including mid-REQ.
- IDLE, op_valid=1:
  - stall=1 combinationally.
  - Register op_type, addr, wdata.
  - Run the checks below. Any failure goes to ERR; otherwise go to REQ.
- Checks:
  - Alignment: lw/sw need addr[1:0]=0; lh/lhu/sh need addr[0]=0.
  - Range: legal regions are 0..DM_TOP, 0x7F00..0x7F0B and 0x7F10..0x7F1B.
  - Timer regions accept word access only.
  - Stores to 0x7F08 or 0x7F18 (count registers) are illegal.
  - Any load failure gives code 4; any store failure gives code 5.
- REQ:
  - Drive m_req=1 with m_we, m_addr, m_be and m_wdata, all from registered values and stable.
  - stall=1.
  - If m_ready=1: capture m_rdata, go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, drop m_req, set code 7 and go to ERR.
  - m_ready while m_req=0 is ignored.
- DONE: done=1, stall=0, exc_valid=0, rdata valid. Next state IDLE. op_valid is ignored in this cycle; the pipeline advances on it.
- ERR: done=1, exc_valid=1, exc_code set, stall=0, rdata=0, no memory traffic. Next state IDLE.
- Minimum latency: op_valid in cycle 0 with m_ready high in cycle 1 gives done in cycle 2. Errors give done in cycle 1.
- Byte enables:
  - word: 4'b1111.
  - half: 4'b0011 << addr[1:0].
  - byte: 4'b0001 << addr[1:0].
  - m_wdata = wdata replicated per lane (byte: {4{b}}; half: {2{h}}).
- Load extend: select the byte/half by addr[1:0] from the captured word. lb/lh sign-extend; lbu/lhu zero-extend.
- Counter resets on entry to REQ.
- Reset and op_valid in the same cycle: reset wins, and the op is not accepted.

Test Plan:
1. sw addr=0x0000_0010, wdata=0x1234_5678, m_ready in the first REQ cycle -> m_req high one cycle, m_be=1111, m_addr=0x10; done in cycle 2; stall high in cycles 0–1.
2. lb addr=0x0000_0013, m_rdata=0x80FF_0000 -> m_be=1000; rdata=0xFFFF_FF80. Repeat with lbu -> rdata=0x0000_0080.
3. lh addr=0x0000_0001 -> no m_req; done+exc_valid in cycle 1; exc_code=4. Then sw addr=0x0000_7F08 -> exc_code=5. Then sb addr=0x0000_7F00 -> exc_code=5.
4. sh addr=0x0000_0002, wdata=0x0000_BEEF, m_ready delayed 3 cycles -> m_req held 4 cycles; m_be=1100; m_wdata=0xBEEF_BEEF; signals stable throughout; done one cycle after m_ready.
5. lw addr=0x0000_0004 with m_ready never asserted and TIMEOUT=16 -> m_req drops after 16 cycles; done with exc_code=7.
6. reset asserted during REQ (second wait cycle) -> next cycle m_req=0, stall=0, done=0; a subsequent lw completes normally.
